// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency memory between the core's
// instruction-fetch port (I, read-only) and data port (D, load/store).
// One transaction is in flight at a time; a three-state FSM (IDLE, BUSY_I,
// BUSY_D) sequences it. A watchdog aborts a transaction the memory never
// acknowledges, and combinational stall requests let the hazard logic freeze
// the fetch / memory stages until their request completes.
//
// Optional feature (compile-time macro ARB_FAIR_EN):
//   defined   - D priority is bounded: after MAX_DBURST consecutive D grants
//               made while I was waiting, the next IDLE cycle grants I.
//   undefined - strict D priority, I may starve (the pipeline releases D).
//
// Parameters:
//   ADDR_W     address width of both ports and of the memory
//   DATA_W     data width
//   TIMEOUT    BUSY cycles without mem_ack before abort (1..65535)
//   MAX_DBURST consecutive D grants allowed while I is pending (ARB_FAIR_EN)
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   i_req/i_addr          fetch request (level, held until i_done) + address
//   i_done/i_rdata        fetch completion pulse + fetch data
//   d_req/d_we/d_addr/d_wdata  data request (level, held until d_done)
//   d_done/d_rdata        data completion pulse + load data
//   mem_req/mem_we/mem_addr/mem_wdata  memory transaction outputs
//   mem_ack/mem_rdata     single-cycle acknowledge, read data valid with it
//   stall_f/stall_m       freeze fetch / memory stage
//   err                   watchdog timeout pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_DBURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              err
);

    // Watchdog counter just wide enough to hold TIMEOUT itself.
    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // Port indices for the per-port vectors below.
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
    logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;

    logic grant_i;
    logic grant_d;
    logic busy;
    logic timeout_hit;
    logic finish;

    logic [1:0] req_vec;
    logic [1:0] owner_vec;
    logic [1:0] done_vec;
    logic [1:0] stall_vec;

    assign busy        = (state_reg != IDLE);
    assign timeout_hit = busy && (wd_cnt_reg == WD_W'(TIMEOUT));
    // Completion (normal or abort). Suppressed while reset is asserted so a
    // transaction killed by reset never reports done.
    assign finish      = ~reset & busy & (mem_ack | timeout_hit);

    assign req_vec[PORT_I]   = i_req;
    assign req_vec[PORT_D]   = d_req;
    assign owner_vec[PORT_I] = (state_reg == BUSY_I);
    assign owner_vec[PORT_D] = (state_reg == BUSY_D);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign done_vec[gi]  = owner_vec[gi] & finish;
            assign stall_vec[gi] = req_vec[gi] & ~done_vec[gi];
        end
    endgenerate

    assign i_done  = done_vec[PORT_I];
    assign d_done  = done_vec[PORT_D];
    assign stall_f = stall_vec[PORT_I];
    assign stall_m = stall_vec[PORT_D];

    // An ack in the watchdog's last cycle wins: that is a normal completion.
    assign err = finish & ~mem_ack;

    assign mem_req   = busy;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Read data is forwarded in the ack cycle and held afterwards. Stores and
    // aborts leave the held value alone.
    assign i_rdata = i_rdata_next;
    assign d_rdata = d_rdata_next;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef ARB_FAIR_EN
    localparam int BC_W = (MAX_DBURST < 1) ? 1 : $clog2(MAX_DBURST + 1);

    logic [BC_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic            burst_full;

    assign burst_full = (burst_cnt_reg == BC_W'(MAX_DBURST));

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            if (i_req && burst_full) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // Counts D grants that overtook a waiting I; saturates at MAX_DBURST.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (state_reg == IDLE) begin
            if (!i_req || grant_i) begin
                burst_cnt_next = '0;
            end else if (grant_d && !burst_full) begin
                burst_cnt_next = burst_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_reg <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`else
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            if (d_req) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // MAX_DBURST only matters for the fair build.
    logic unused_burst_cfg;
    assign unused_burst_cfg = (MAX_DBURST != 0);
`endif

    // -------------------------------------------------------------------------
    // Next-state and capture logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        mem_addr_next  = mem_addr_reg;
        mem_we_next    = mem_we_reg;
        mem_wdata_next = mem_wdata_reg;
        wd_cnt_next    = wd_cnt_reg;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;

        case (state_reg)
            IDLE: begin
                // mem_ack is ignored here; only a grant moves the FSM.
                if (grant_d) begin
                    state_next     = BUSY_D;
                    mem_addr_next  = d_addr;
                    mem_we_next    = d_we;
                    mem_wdata_next = d_wdata;
                    wd_cnt_next    = '0;
                end else if (grant_i) begin
                    // Write data is meaningless for a fetch and is left as is.
                    state_next    = BUSY_I;
                    mem_addr_next = i_addr;
                    mem_we_next   = 1'b0;
                    wd_cnt_next   = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || timeout_hit) begin
                    state_next = IDLE;
                end else begin
                    // timeout_hit is clear here, so this never wraps.
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (done_vec[PORT_I] && mem_ack) begin
            i_rdata_next = mem_rdata;
        end
        if (done_vec[PORT_D] && mem_ack && !mem_we_reg) begin
            d_rdata_next = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
            wd_cnt_reg    <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            mem_addr_reg  <= mem_addr_next;
            mem_we_reg    <= mem_we_next;
            mem_wdata_reg <= mem_wdata_next;
            wd_cnt_reg    <= wd_cnt_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (TIMEOUT=8, MAX_DBURST=4).
// A transaction-level reference (who owns the memory, what was captured at the
// grant, how long it has waited, last read data per port) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
// Honours ARB_FAIR_EN if it is defined for the whole compile.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TO   = 8;
    localparam int MAXB = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;
    logic        err;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (TO),
        .MAX_DBURST(MAXB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: 0 = memory free, 1 = owned by I, 2 = owned by D.
    int          m_owner  = 0;
    logic [31:0] m_addr   = '0;
    logic        m_we     = 1'b0;
    logic [31:0] m_wdata  = '0;
    int          m_waited = 0;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;
`ifdef ARB_FAIR_EN
    int          m_burst  = 0;
`endif

    logic last_i_done = 1'b0;
    logic last_d_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called 1 time unit after a rising edge, with inputs already driven:
    // moves to the falling edge and checks every output against the reference.
    task automatic settle();
        logic        hit, fin, e_idone, e_ddone, e_err;
        logic [31:0] e_ir, e_dr;
        #4;
        hit     = (m_owner != 0) && (m_waited == TO);
        fin     = !reset && (m_owner != 0) && (mem_ack || hit);
        e_idone = fin && (m_owner == 1);
        e_ddone = fin && (m_owner == 2);
        e_err   = fin && !mem_ack;
        e_ir    = (e_idone && mem_ack) ? mem_rdata : m_irdata;
        e_dr    = (e_ddone && mem_ack && !m_we) ? mem_rdata : m_drdata;
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_owner != 0});
        if (m_owner != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("i_done", {31'b0, i_done}, {31'b0, e_idone});
        chk("d_done", {31'b0, d_done}, {31'b0, e_ddone});
        chk("err", {31'b0, err}, {31'b0, e_err});
        chk("i_rdata", i_rdata, e_ir);
        chk("d_rdata", d_rdata, e_dr);
        chk("stall_f", {31'b0, stall_f}, {31'b0, i_req & ~e_idone});
        chk("stall_m", {31'b0, stall_m}, {31'b0, d_req & ~e_ddone});
        if (fin) begin
            $display("txn %s addr=0x%08h we=%0d rdata=0x%08h %s @%0t",
                     (m_owner == 1) ? "I" : "D", m_addr, m_we,
                     (m_owner == 1) ? e_ir : e_dr, e_err ? "timeout" : "ok", $time);
        end
        last_i_done = e_idone;
        last_d_done = e_ddone;
    endtask

    // Applies the rising edge to the reference, then waits for it in the DUT.
    task automatic advance();
        int g;
        if (reset) begin
            m_owner  = 0;
            m_addr   = '0;
            m_we     = 1'b0;
            m_wdata  = '0;
            m_waited = 0;
            m_irdata = '0;
            m_drdata = '0;
`ifdef ARB_FAIR_EN
            m_burst  = 0;
`endif
        end else if (m_owner == 0) begin
            g = 0;
`ifdef ARB_FAIR_EN
            if (i_req && m_burst == MAXB) g = 1;
            else if (d_req) g = 2;
            else if (i_req) g = 1;
            if (!i_req || g == 1) m_burst = 0;
            else if (g == 2 && m_burst < MAXB) m_burst++;
`else
            if (d_req) g = 2;
            else if (i_req) g = 1;
`endif
            if (g == 2) begin
                m_addr  = d_addr;
                m_we    = d_we;
                m_wdata = d_wdata;
            end else if (g == 1) begin
                m_addr = i_addr;
                m_we   = 1'b0;
            end
            m_owner  = g;
            m_waited = 0;
        end else begin
            if (mem_ack) begin
                if (m_owner == 1) m_irdata = mem_rdata;
                else if (!m_we) m_drdata = mem_rdata;
                m_owner = 0;
            end else if (m_waited == TO) begin
                m_owner = 0;
            end else begin
                m_waited++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        string got;
        string want;
        int    n;
        int    resp_cnt;
        int    resp_lat;
        logic  prev_busy;

        reset     = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(posedge clk);
        #1;

        // Reset state
        settle();
        chk("lit_reset_mem_req", {31'b0, mem_req}, 32'd0);
        chk("lit_reset_mem_addr", mem_addr, 32'd0);
        chk("lit_reset_i_rdata", i_rdata, 32'd0);
        chk("lit_reset_d_rdata", d_rdata, 32'd0);
        chk("lit_reset_err", {31'b0, err}, 32'd0);
        advance();
        reset = 1'b0;

        // Single fetch, ack three cycles after mem_req rises
        i_req  = 1'b1;
        i_addr = 32'h100;
        settle();
        chk("lit_fetch_grant_cycle_req", {31'b0, mem_req}, 32'd0);
        advance();
        for (int k = 0; k < 4; k++) begin
            mem_ack   = (k == 3);
            mem_rdata = (k == 3) ? 32'hE3A01005 : $urandom;
            settle();
            if (k == 0) begin
                chk("lit_fetch_addr", mem_addr, 32'h100);
                chk("lit_fetch_we", {31'b0, mem_we}, 32'd0);
                chk("lit_fetch_stall_busy", {31'b0, stall_f}, 32'd1);
            end
            if (k == 3) begin
                chk("lit_fetch_done", {31'b0, i_done}, 32'd1);
                chk("lit_fetch_rdata", i_rdata, 32'hE3A01005);
                chk("lit_fetch_stall_done", {31'b0, stall_f}, 32'd0);
            end
            advance();
        end
        i_req   = 1'b0;
        mem_ack = 1'b0;
        settle();
        chk("lit_fetch_rdata_held", i_rdata, 32'hE3A01005);
        advance();

        // Simultaneous requests: D store first, address frozen, then I
        i_req   = 1'b1;
        i_addr  = 32'h104;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEADBEEF;
        settle();
        advance();
        d_addr = 32'h3000;
        settle();
        chk("lit_sim_we", {31'b0, mem_we}, 32'd1);
        chk("lit_sim_wdata", mem_wdata, 32'hDEADBEEF);
        chk("lit_sim_addr_held", mem_addr, 32'h2000);
        chk("lit_sim_stall_f", {31'b0, stall_f}, 32'd1);
        advance();
        mem_ack = 1'b1;
        settle();
        chk("lit_sim_addr_at_done", mem_addr, 32'h2000);
        chk("lit_sim_d_done", {31'b0, d_done}, 32'd1);
        chk("lit_sim_stall_f_d_done", {31'b0, stall_f}, 32'd1);
        advance();
        d_req   = 1'b0;
        mem_ack = 1'b0;
        settle();
        chk("lit_sim_idle_stall_f", {31'b0, stall_f}, 32'd1);
        advance();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_1111;
        settle();
        chk("lit_sim_i_addr", mem_addr, 32'h104);
        chk("lit_sim_i_done", {31'b0, i_done}, 32'd1);
        chk("lit_sim_stall_f_clear", {31'b0, stall_f}, 32'd0);
        advance();
        i_req   = 1'b0;
        mem_ack = 1'b0;
        settle();
        advance();

        // Load, then a back-to-back load the memory never acknowledges
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
        settle();
        advance();
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        settle();
        chk("lit_load_rdata", d_rdata, 32'h12345678);
        advance();
        mem_ack = 1'b0;
        d_addr  = 32'h40;
        settle();
        chk("lit_b2b_idle_cycle", {31'b0, mem_req}, 32'd0);
        advance();
        for (int k = 0; k <= TO; k++) begin
            mem_rdata = $urandom;
            settle();
            if (k < TO) begin
                chk("lit_wd_no_err_early", {31'b0, err}, 32'd0);
                chk("lit_wd_no_done_early", {31'b0, d_done}, 32'd0);
            end else begin
                chk("lit_wd_err", {31'b0, err}, 32'd1);
                chk("lit_wd_done", {31'b0, d_done}, 32'd1);
                chk("lit_wd_rdata_kept", d_rdata, 32'h12345678);
            end
            advance();
        end
        d_req = 1'b0;
        settle();
        chk("lit_wd_back_idle", {31'b0, mem_req}, 32'd0);
        advance();

        // Reset in the third BUSY cycle, then a stray ack
        d_req  = 1'b1;
        d_addr = 32'h500;
        settle();
        advance();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) reset = 1'b1;
            settle();
            advance();
        end
        reset     = 1'b0;
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        settle();
        chk("lit_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("lit_rst_d_done", {31'b0, d_done}, 32'd0);
        chk("lit_rst_err", {31'b0, err}, 32'd0);
        chk("lit_rst_mem_addr", mem_addr, 32'd0);
        chk("lit_rst_d_rdata", d_rdata, 32'd0);
        chk("lit_rst_i_rdata", i_rdata, 32'd0);
        advance();
        mem_ack = 1'b0;

        // Grant order with both ports requesting continuously
        i_req = 1'b1;
        d_req = 1'b1;
        d_we  = 1'b0;
        got   = "";
        n     = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            mem_ack   = (m_owner != 0);
            mem_rdata = $urandom;
            i_addr    = $urandom;
            d_addr    = $urandom;
            settle();
            if (i_done || d_done) begin
                got = {got, d_done ? "D" : "I"};
                n++;
            end
            advance();
        end
`ifdef ARB_FAIR_EN
        want = "DDDDIDDDDI";
`else
        want = "DDDDDDDDDD";
`endif
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL grant_order: got %s expected %s", got, want);
        end
        i_req   = 1'b0;
        d_req   = 1'b0;
        mem_ack = 1'b0;
        settle();
        advance();

        // Randomized traffic against the reference
        resp_cnt  = 0;
        resp_lat  = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);

            if (!i_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    i_req  = 1'b1;
                    i_addr = $urandom;
                end
            end else if (last_i_done) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                i_addr = $urandom;
            end

            if (!d_req) begin
                if ($urandom_range(0, 99) < 30) begin
                    d_req   = 1'b1;
                    d_we    = $urandom_range(0, 1) == 1;
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end else if (last_d_done) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_req = 1'b0;
                end else begin
                    d_we    = $urandom_range(0, 1) == 1;
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end

            if (m_owner != 0) begin
                if (!prev_busy) begin
                    resp_cnt = 0;
                    resp_lat = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 3);
                end else begin
                    resp_cnt++;
                end
                mem_ack = (resp_cnt == resp_lat);
            end else begin
                mem_ack = ($urandom_range(0, 9) == 0);
            end
            prev_busy = (m_owner != 0);
            mem_rdata = $urandom;

            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipelined core's instruction-fetch port (I, read-only) and data port (D, load/store).
- Sequences each memory transaction with a small state machine.
- Drives stall requests that the hazard logic uses to freeze the fetch or memory stage.
- Includes a watchdog that aborts a transaction the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles in BUSY waiting for mem_ack before abort; range 1..65535.
- MAX_DBURST, 4, consecutive D grants allowed while I is pending (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  fetch request (level); held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_done  out  1  fetch completion pulse.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request (level); held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  data completion pulse.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- stall_f  out  1  freeze fetch stage.
- stall_m  out  1  freeze memory stage.
- err  out  1  timeout pulse.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset (synchronous, active-high) forces IDLE.
- Reset values: mem_req/mem_we/i_done/d_done/err = 0; mem_addr, mem_wdata, i_rdata, d_rdata, watchdog counter and burst counter = 0.
- Arbitration in IDLE:
  - d_req=1 -> BUSY_D. D wins when both are requesting.
  - Else i_req=1 -> BUSY_I.
  - Else stay in IDLE.
- Grant capture: mem_addr, mem_we (d_we, or 0 for I) and mem_wdata are registered on the grant edge. Later changes on the requester's inputs are ignored until completion.
- mem_req = 1 exactly while state is BUSY_I or BUSY_D. First mem_req cycle is the cycle after the grant.
- Completion:
  - In BUSY_x with mem_ack=1: x_done=1 in that same cycle, combinational.
  - x_rdata = mem_rdata in that cycle, then registered and held until the next completion of that port. Stores leave d_rdata unchanged.
  - Next state is IDLE. Minimum transaction is 2 cycles: grant edge, then ack in the first BUSY cycle.
- Back-to-back: a requester still asserting req in the cycle after done starts a new transaction. IDLE re-arbitrates every cycle it is entered, so there are no idle bubbles beyond the one IDLE cycle.
- mem_ack in IDLE is ignored: no done, no state change.
- Stalls, both combinational:
  - stall_f = i_req & ~i_done.
  - stall_m = d_req & ~d_done.
- Watchdog:
  - Counter clears on every grant and increments each BUSY cycle without ack.
  - Abort when count reaches TIMEOUT without ack: err pulses 1 cycle, x_done pulses in the same cycle (x_rdata unchanged), state goes to IDLE.
  - mem_ack arriving in the abort cycle takes precedence: normal completion, err=0.
- Reset mid-transaction: IDLE at the next edge, mem_req low from that cycle, no done pulse. A stale mem_ack afterwards is ignored.
- Widths: watchdog counter is ceil(log2(TIMEOUT+1)) bits and must not wrap. Burst counter saturates at MAX_DBURST.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A burst counter counts consecutive D grants made while i_req=1.
  - When it equals MAX_DBURST and i_req=1, IDLE grants I even if d_req=1.
  - The counter clears on any I grant, or on any IDLE cycle with i_req=0.
- Undefined: strict D priority, no burst counter. Starvation of I is allowed; the pipeline guarantees D is released.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory acks 3 cycles after mem_req rises with rdata=0xE3A01005 -> mem_addr=0x100, mem_we=0, i_done pulses in the ack cycle, i_rdata=0xE3A01005, stall_f=0 from that cycle.
- Simultaneous requests: i_req=1 (0x104) and d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF in the same cycle -> D transaction first with mem_we=1, mem_wdata=0xDEADBEEF; stall_f stays 1 until I completes afterwards at 0x104.
- Address held after grant: change d_addr to 0x3000 one cycle after a grant at 0x2000 -> mem_addr stays 0x2000 until d_done.
- Timeout with TIMEOUT=8, ack never asserted -> err and d_done pulse exactly 8 BUSY cycles after mem_req rises, d_rdata unchanged, state IDLE.
- Reset mid-transaction (3rd BUSY cycle) then stray mem_ack -> mem_req=0 after the reset edge, no done, no err, all outputs at reset values.
- ARB_FAIR_EN with MAX_DBURST=4: d_req and i_req held continuously, ack latency 1 -> grant order D,D,D,D,I,D,D,D,D,I; without the macro, only D grants.
